// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS sequencer: fetch/decode/execute/memory/writeback FSM
module multicycle_control (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       memReady,
   output logic       pcWrite,
   output logic       irWrite,
   output logic       memRead,
   output logic       memWrite,
   output logic       regWrite,
   output logic [1:0] regDst,
   output logic [1:0] memToReg,
   output logic       aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [2:0] aluOp,
   output logic [1:0] extType,
   output logic [1:0] pcSrc,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9,
      IEXEC  = 4'd10,
      IWB    = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b010;
   localparam logic [2:0] ALU_SLT = 3'b011;
   localparam logic [2:0] ALU_LUI = 3'b100;

   state_t curState;
   state_t nextState;
   logic   isJr;

   assign state = curState;
   assign isJr  = (opcode == OP_RTYPE) && (funct == FN_JR);

   // State register; reset aborts whatever instruction is in flight
   always_ff @(posedge clk) begin
      if (rst) curState <= FETCH;
      else     curState <= nextState;
   end

   // Next-state and control decode; all controls forced low while rst is high
   always_comb begin
      nextState = FETCH;
      pcWrite   = 1'b0;
      irWrite   = 1'b0;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      regWrite  = 1'b0;
      regDst    = 2'b00;
      memToReg  = 2'b00;
      aluSrcA   = 1'b0;
      aluSrcB   = 2'b00;
      aluOp     = ALU_ADD;
      extType   = 2'b00;
      pcSrc     = 2'b00;
      case (curState)
         FETCH: begin
            memRead = 1'b1;
            aluSrcB = 2'b01;
            if (memReady) begin
               irWrite   = 1'b1;
               pcWrite   = 1'b1;
               nextState = DECODE;
            end else begin
               nextState = FETCH;
            end
         end
         DECODE: begin
            // Branch target computed speculatively into ALUOut
            aluSrcB = 2'b11;
            case (opcode)
               OP_RTYPE:      nextState = isJr ? JUMP : EXEC;
               OP_LW, OP_SW:  nextState = MEMADR;
               OP_BEQ:        nextState = BRANCH;
               OP_ORI, OP_LUI: nextState = IEXEC;
               OP_J, OP_JAL:  nextState = JUMP;
               default:       nextState = FETCH;
            endcase
         end
         MEMADR: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'b10;
            if (opcode == OP_LW)      nextState = MEMRD;
            else if (opcode == OP_SW) nextState = MEMWR;
            else                      nextState = FETCH;
         end
         MEMRD: begin
            memRead   = 1'b1;
            nextState = memReady ? MEMWB : MEMRD;
         end
         MEMWB: begin
            regWrite = 1'b1;
            memToReg = 2'b01;
         end
         MEMWR: begin
            memWrite  = 1'b1;
            nextState = memReady ? FETCH : MEMWR;
         end
         EXEC: begin
            aluSrcA   = 1'b1;
            nextState = ALUWB;
            case (funct)
               6'b100011: aluOp = ALU_SUB;
               6'b100101: aluOp = ALU_OR;
               6'b101010: aluOp = ALU_SLT;
               default:   aluOp = ALU_ADD;
            endcase
         end
         ALUWB: begin
            regWrite = 1'b1;
            regDst   = 2'b01;
         end
         BRANCH: begin
            aluSrcA = 1'b1;
            aluOp   = ALU_SUB;
            pcSrc   = 2'b01;
            pcWrite = zero;
         end
         JUMP: begin
            pcWrite = 1'b1;
            pcSrc   = isJr ? 2'b11 : 2'b10;
            // jal links PC (already PC+4) into $31
            if (opcode == OP_JAL) begin
               regWrite = 1'b1;
               regDst   = 2'b10;
               memToReg = 2'b10;
            end
         end
         IEXEC: begin
            aluSrcA   = 1'b1;
            aluSrcB   = 2'b10;
            nextState = IWB;
            if (opcode == OP_ORI) begin
               extType = 2'b01;
               aluOp   = ALU_OR;
            end else begin
               aluOp   = ALU_LUI;
            end
         end
         IWB: begin
            regWrite = 1'b1;
         end
         default: nextState = FETCH;
      endcase
      if (rst) begin
         pcWrite  = 1'b0;
         irWrite  = 1'b0;
         memRead  = 1'b0;
         memWrite = 1'b0;
         regWrite = 1'b0;
         regDst   = 2'b00;
         memToReg = 2'b00;
         aluSrcA  = 1'b0;
         aluSrcB  = 2'b00;
         aluOp    = ALU_ADD;
         extType  = 2'b00;
         pcSrc    = 2'b00;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - table-driven scoreboard bench for multicycle_control
module tb_multicycle_control;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic [5:0] opcode = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       zero = 1'b0;
   logic       memReady = 1'b0;
   logic       pcWrite, irWrite, memRead, memWrite, regWrite, aluSrcA;
   logic [1:0] regDst, memToReg, aluSrcB, extType, pcSrc;
   logic [2:0] aluOp;
   logic [3:0] state;
   logic [18:0] outs;

   multicycle_control dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .memReady(memReady), .pcWrite(pcWrite), .irWrite(irWrite),
      .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite),
      .regDst(regDst), .memToReg(memToReg), .aluSrcA(aluSrcA),
      .aluSrcB(aluSrcB), .aluOp(aluOp), .extType(extType), .pcSrc(pcSrc),
      .state(state)
   );

   assign outs = {pcWrite, irWrite, memRead, memWrite, regWrite, regDst, memToReg,
                  aluSrcA, aluSrcB, aluOp, extType, pcSrc};

   typedef struct packed {
      int          idx;
      logic        r;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        z;
      logic        mr;
      logic        chk;
      logic [3:0]  st;
      logic [18:0] out;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [18:0] ctl(input logic pcW, input logic irW, input logic mR,
                                       input logic mW, input logic rW, input logic [1:0] rd,
                                       input logic [1:0] m2r, input logic sA, input logic [1:0] sB,
                                       input logic [2:0] op, input logic [1:0] ext,
                                       input logic [1:0] ps);
      return {pcW, irW, mR, mW, rW, rd, m2r, sA, sB, op, ext, ps};
   endfunction

   task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input logic mr, input logic chk, input logic [3:0] st,
                      input logic [18:0] out);
      vec_t v;
      v.idx = vecs.size();
      v.r = r; v.op = op; v.fn = fn; v.z = z; v.mr = mr;
      v.chk = chk; v.st = st; v.out = out;
      vecs.push_back(v);
   endtask

   // Instruction fetch (memory ready) then decode with memReady low to show it is ignored
   task automatic fetchDecode(input logic [5:0] op, input logic [5:0] fn);
      add(1'b0, op, fn, 1'b0, 1'b1, 1'b1, 4'd0, ctl(1,1,1,0,0,2'b00,2'b00,0,2'b01,3'b000,2'b00,2'b00));
      add(1'b0, op, fn, 1'b0, 1'b0, 1'b1, 4'd1, ctl(0,0,0,0,0,2'b00,2'b00,0,2'b11,3'b000,2'b00,2'b00));
   endtask

   // Pop expected record and compare against outputs away from the clock edge
   always @(negedge clk) begin
      vec_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (outs !== e.out || (e.chk && state !== e.st)) begin
            errors++;
            $display("FAIL vec%0d: state=%0d outs=%05h, required state=%0d outs=%05h",
                     e.idx, state, outs, e.st, e.out);
         end
      end
   end

   initial begin
      logic [18:0] o0, oFs, oMA, oMR, oMW;
      logic [5:0]  fns [5];
      logic [2:0]  ops [5];
      logic [5:0]  LW, SW, BEQ;
      o0  = 19'd0;
      oFs = ctl(0,0,1,0,0,2'b00,2'b00,0,2'b01,3'b000,2'b00,2'b00);
      oMA = ctl(0,0,0,0,0,2'b00,2'b00,1,2'b10,3'b000,2'b00,2'b00);
      oMR = ctl(0,0,1,0,0,2'b00,2'b00,0,2'b00,3'b000,2'b00,2'b00);
      oMW = ctl(0,0,0,1,0,2'b00,2'b00,0,2'b00,3'b000,2'b00,2'b00);
      LW = 6'b100011; SW = 6'b101011; BEQ = 6'b000100;
      fns = '{6'b100001, 6'b100011, 6'b100101, 6'b101010, 6'b000000};
      ops = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b000};

      // Reset, with memReady high to show outputs stay forced low
      add(1'b1, 6'd0, 6'd0, 1'b0, 1'b1, 1'b0, 4'd0, o0);
      add(1'b1, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1, 4'd0, o0);
      // R-type: addu, subu, or, slt, unlisted funct
      for (int k = 0; k < 5; k++) begin
         fetchDecode(6'd0, fns[k]);
         add(1'b0, 6'd0, fns[k], 1'b0, 1'b1, 1'b1, 4'd6, ctl(0,0,0,0,0,2'b00,2'b00,1,2'b00,ops[k],2'b00,2'b00));
         add(1'b0, 6'd0, fns[k], 1'b0, 1'b1, 1'b1, 4'd7, ctl(0,0,0,0,1,2'b01,2'b00,0,2'b00,3'b000,2'b00,2'b00));
      end
      // lw with three stall cycles in MEMRD
      fetchDecode(LW, 6'd0);
      add(1'b0, LW, 6'd0, 1'b0, 1'b0, 1'b1, 4'd2, oMA);
      for (int k = 0; k < 3; k++) add(1'b0, LW, 6'd0, 1'b0, 1'b0, 1'b1, 4'd3, oMR);
      add(1'b0, LW, 6'd0, 1'b0, 1'b1, 1'b1, 4'd3, oMR);
      add(1'b0, LW, 6'd0, 1'b0, 1'b1, 1'b1, 4'd4, ctl(0,0,0,0,1,2'b00,2'b01,0,2'b00,3'b000,2'b00,2'b00));
      // sw with one fetch stall
      add(1'b0, SW, 6'd0, 1'b0, 1'b0, 1'b1, 4'd0, oFs);
      fetchDecode(SW, 6'd0);
      add(1'b0, SW, 6'd0, 1'b0, 1'b1, 1'b1, 4'd2, oMA);
      add(1'b0, SW, 6'd0, 1'b0, 1'b1, 1'b1, 4'd5, oMW);
      // beq taken then not taken
      fetchDecode(BEQ, 6'd0);
      add(1'b0, BEQ, 6'd0, 1'b1, 1'b1, 1'b1, 4'd8, ctl(1,0,0,0,0,2'b00,2'b00,1,2'b00,3'b001,2'b00,2'b01));
      fetchDecode(BEQ, 6'd0);
      add(1'b0, BEQ, 6'd0, 1'b0, 1'b1, 1'b1, 4'd8, ctl(0,0,0,0,0,2'b00,2'b00,1,2'b00,3'b001,2'b00,2'b01));
      // jal, j, jr
      fetchDecode(6'b000011, 6'd0);
      add(1'b0, 6'b000011, 6'd0, 1'b0, 1'b1, 1'b1, 4'd9, ctl(1,0,0,0,1,2'b10,2'b10,0,2'b00,3'b000,2'b00,2'b10));
      fetchDecode(6'b000010, 6'd0);
      add(1'b0, 6'b000010, 6'd0, 1'b0, 1'b1, 1'b1, 4'd9, ctl(1,0,0,0,0,2'b00,2'b00,0,2'b00,3'b000,2'b00,2'b10));
      fetchDecode(6'd0, 6'b001000);
      add(1'b0, 6'd0, 6'b001000, 1'b0, 1'b1, 1'b1, 4'd9, ctl(1,0,0,0,0,2'b00,2'b00,0,2'b00,3'b000,2'b00,2'b11));
      // ori, lui
      fetchDecode(6'b001101, 6'd0);
      add(1'b0, 6'b001101, 6'd0, 1'b0, 1'b1, 1'b1, 4'd10, ctl(0,0,0,0,0,2'b00,2'b00,1,2'b10,3'b010,2'b01,2'b00));
      add(1'b0, 6'b001101, 6'd0, 1'b0, 1'b1, 1'b1, 4'd11, ctl(0,0,0,0,1,2'b00,2'b00,0,2'b00,3'b000,2'b00,2'b00));
      fetchDecode(6'b001111, 6'd0);
      add(1'b0, 6'b001111, 6'd0, 1'b0, 1'b1, 1'b1, 4'd10, ctl(0,0,0,0,0,2'b00,2'b00,1,2'b10,3'b100,2'b00,2'b00));
      add(1'b0, 6'b001111, 6'd0, 1'b0, 1'b1, 1'b1, 4'd11, ctl(0,0,0,0,1,2'b00,2'b00,0,2'b00,3'b000,2'b00,2'b00));
      // Illegal opcode returns straight to FETCH (checked by the following fetch entry)
      fetchDecode(6'b111111, 6'd0);
      // sw aborted by reset during MEMWR stall
      fetchDecode(SW, 6'd0);
      add(1'b0, SW, 6'd0, 1'b0, 1'b0, 1'b1, 4'd2, oMA);
      add(1'b0, SW, 6'd0, 1'b0, 1'b0, 1'b1, 4'd5, oMW);
      add(1'b1, SW, 6'd0, 1'b0, 1'b0, 1'b1, 4'd5, o0);
      add(1'b0, SW, 6'd0, 1'b0, 1'b0, 1'b1, 4'd0, oFs);
      fetchDecode(SW, 6'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk);
         #1;
         rst      = vecs[i].r;
         opcode   = vecs[i].op;
         funct    = vecs[i].fn;
         zero     = vecs[i].z;
         memReady = vecs[i].mr;
         sb.push_back(vecs[i]);
      end
      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: pending=%0d, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle sequencer for the MIPS datapath. Replaces single-cycle decode with a Moore/Mealy FSM that steps each instruction through fetch, decode, execute, memory and writeback.
- Drives PC/IR write enables, mux selects and ALU op for a shared-ALU, shared-memory datapath.
- Stalls on a memory ready handshake.
- Sits beside the datapath under the mips top level. Consumes IR opcode/funct and ALU zero.

Parameters:
- RA_REG, 5'd31, register index written by jal (informational; the datapath applies it when regDst=2'b10).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous reset, active-high
- opcode  input  6  IR[31:26], stable from DECODE onward
- funct  input  6  IR[5:0]
- zero  input  1  ALU zero flag, combinational from datapath
- memReady  input  1  memory completed access this cycle
- pcWrite  output  1  load PC
- irWrite  output  1  load IR
- memRead  output  1  memory read request
- memWrite  output  1  memory write request
- regWrite  output  1  register file write
- regDst  output  2  00 rt, 01 rd, 10 $31
- memToReg  output  2  00 ALUOut, 01 MDR, 10 PC
- aluSrcA  output  1  0 PC, 1 regA
- aluSrcB  output  2  00 regB, 01 const 4, 10 ext imm, 11 ext imm<<2
- aluOp  output  3  000 ADD, 001 SUB, 010 OR, 011 SLT, 100 LUI
- extType  output  2  00 sign, 01 zero
- pcSrc  output  2  00 ALU result, 01 ALUOut, 10 {PC[31:28],IR[25:0],2'b00}, 11 regA
- state  output  4  current state, debug

Behaviour:
- Reset: synchronous. While rst=1, every output other than state is 0. At the next edge state=FETCH (0).
- Default: every output not listed for a state is 0.
- States, with their encodings and actions:
  - FETCH(0): memRead=1, aluSrcA=0, aluSrcB=01, aluOp=ADD, pcSrc=00. While memReady=0: hold, irWrite=pcWrite=0. When memReady=1: irWrite=1, pcWrite=1, go to DECODE.
  - DECODE(1): aluSrcA=0, aluSrcB=11, extType=00, aluOp=ADD (branch target into ALUOut). Next state by opcode:
    - 000000: funct 001000 (jr) -> JUMP; else -> EXEC.
    - 100011 lw, 101011 sw -> MEMADR.
    - 000100 beq -> BRANCH.
    - 001101 ori, 001111 lui -> IEXEC.
    - 000010 j, 000011 jal -> JUMP.
    - Any other opcode -> FETCH, no writes (treated as nop).
  - MEMADR(2): aluSrcA=1, aluSrcB=10, extType=00, aluOp=ADD. lw -> MEMRD, sw -> MEMWR.
  - MEMRD(3): memRead=1. Hold until memReady, then -> MEMWB.
  - MEMWB(4): regWrite=1, regDst=00, memToReg=01. -> FETCH.
  - MEMWR(5): memWrite=1. Hold until memReady, then -> FETCH.
  - EXEC(6): aluSrcA=1, aluSrcB=00. aluOp from funct: 100001->ADD, 100011->SUB, 100101->OR, 101010->SLT; other funct->ADD. -> ALUWB.
  - ALUWB(7): regWrite=1, regDst=01, memToReg=00. -> FETCH.
  - BRANCH(8): aluSrcA=1, aluSrcB=00, aluOp=SUB, pcSrc=01, pcWrite=zero (same-cycle). -> FETCH.
  - JUMP(9): pcWrite=1. pcSrc=11 for jr, else 10. For jal also regWrite=1, regDst=10, memToReg=10 (PC already holds PC+4). -> FETCH.
  - IEXEC(10): aluSrcA=1, aluSrcB=10. ori: extType=01, aluOp=OR. lui: aluOp=LUI. -> IWB.
  - IWB(11): regWrite=1, regDst=00, memToReg=00. -> FETCH.
  - Encodings 12-15: -> FETCH, all outputs 0.
- Latency with memReady tied 1: R-type 4, ori/lui 4, sw 4, lw 5, beq 3, j/jal/jr 3 cycles.
- memReady is sampled only in FETCH, MEMRD and MEMWR; elsewhere it is ignored.
- memRead/memWrite stay asserted, unchanged, for every stall cycle.
- rst=1 mid-instruction aborts it at that edge: no further writes, restart at FETCH.
- pcWrite and regWrite are never asserted in the same cycle except in JUMP for jal.

Test Plan:
- Reset: rst=1 for 2 cycles from any state -> all outputs 0 and state=0 one edge after release; first cycle after release shows memRead=1.
- addu (opcode 0, funct 100001), memReady=1 -> states 0,1,6,7,0. In state 7: regWrite=1, regDst=01, aluOp ADD seen in state 6. subu/or/slt give aluOp 001/010/011.
- lw with memReady low 3 cycles in MEMRD -> state 3 held 4 cycles with memRead=1. Then state 4 with regWrite=1, memToReg=01. Total 8 cycles.
- beq twice, zero=1 then zero=0 -> states 0,1,8 each. pcWrite=1 with pcSrc=01 in the first; pcWrite=0 in the second.
- jal -> state 9 with pcWrite=1, pcSrc=10, regWrite=1, regDst=10, memToReg=10. jr (funct 001000) -> pcSrc=11, regWrite=0.
- Illegal opcode 111111 -> 0,1,0 with no write enables. rst asserted during MEMWR stall -> memWrite drops to 0 immediately, state 0 next.
